pll_lock_sequencer: RTL and testbench

Power-up and recovery controller for the board PLL. Runs on the PLL reference clock (24 MHz board clock) and drives the PLL's active-high RST. Watches the asynchronous PLL lock output, holds the system reset until lock has been stable for a programmable time, and re-initialises the PLL on lock loss or lock timeout. After a bounded number of failed attempts it enters a sticky failure state.

---
 rtl/pll_seq_pkg.sv | 32 +++
 rtl/pll_lock_sync.sv | 23 ++
 rtl/pll_lock_sequencer.sv | 138 +++++++++++++
 tb/tb_pll_lock_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding and width helpers.
package pll_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    // Ceiling log2, never below 1 so a degenerate parameter still yields a usable vector.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-stage synchroniser bringing the asynchronous PLL lock flag into the clk domain.
module pll_lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/recovery sequencer: pulses the PLL reset, qualifies lock, and holds
// the system in reset until lock is stable, retrying a bounded number of times.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter  int RST_CYCLES     = 24,
    parameter  int LOCK_CYCLES    = 2400,
    parameter  int TIMEOUT_CYCLES = 240000,
    parameter  int MAX_RETRY      = 3,
    localparam int RETRY_W        = clog2(MAX_RETRY + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [STATE_W-1:0] state
);

    localparam int CNT_W = clog2(max3(RST_CYCLES, LOCK_CYCLES, TIMEOUT_CYCLES) + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST    = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    logic               locked_s;
    state_t             state_q;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_next;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_next;

    pll_lock_sync #(
        .STAGES(2)
    ) u_lock_sync (
        .clk     (clk),
        .resetn  (resetn),
        .async_in(pll_locked),
        .sync_out(locked_s)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_PLL_RST;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            retry_q <= retry_next;
        end
    end

    // restart wins over every other transition; lock is checked before the
    // timeout/window end so a simultaneous change never mis-steps.
    always_comb begin
        state_next = state_q;
        retry_next = retry_q;
        if (restart) begin
            state_next = ST_PLL_RST;
            retry_next = '0;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_next = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_next = ST_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q == RETRY_LIMIT) begin
                            state_next = ST_FAIL;
                        end else begin
                            state_next = ST_PLL_RST;
                            retry_next = retry_q + RETRY_W'(1);
                        end
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_next = ST_WAIT_LOCK;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_next = ST_RUN;
                        retry_next = '0;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_next = ST_PLL_RST;
                    end
                end
                ST_FAIL: begin
                    state_next = ST_FAIL;
                end
                default: begin
                    state_next = ST_PLL_RST;
                end
            endcase
        end
    end

    always_comb begin
        cnt_next = cnt_q;
        if (restart || (state_next != state_q)) begin
            cnt_next = '0;
        end else if ((state_q == ST_PLL_RST) || (state_q == ST_WAIT_LOCK) ||
                     (state_q == ST_STABLE)) begin
            cnt_next = cnt_q + CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state so they flip on the same edge as state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            pll_rst   <= (state_next == ST_PLL_RST) || (state_next == ST_FAIL);
            sys_rst_n <= (state_next == ST_RUN);
            ready     <= (state_next == ST_RUN);
            fail      <= (state_next == ST_FAIL);
        end
    end

    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: a table of timed input steps, each
// with the expected output snapshot, checked through a small expectation queue.
module tb_pll_lock_sequencer;

    logic       clk;
    logic       resetn;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int total;
    int bad;

    typedef struct {
        logic       rn;
        logic       lk;
        logic       rs;
        int         ncyc;
        logic [8:0] exp;
    } vec_t;

    vec_t       vecs[$];
    string      names[$];
    logic [8:0] exp_q[$];

    pll_lock_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_CYCLES   (8),
        .TIMEOUT_CYCLES(32),
        .MAX_RETRY     (2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .pll_locked(pll_locked),
        .restart   (restart),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .state     (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic addv(input string nm, input logic rn, input logic lk, input logic rs,
                        input int n, input logic pr, input logic sr, input logic rd,
                        input logic fl, input logic [1:0] rc, input logic [2:0] st);
        vec_t v;
        v.rn   = rn;
        v.lk   = lk;
        v.rs   = rs;
        v.ncyc = n;
        v.exp  = {pr, sr, rd, fl, rc, st};
        vecs.push_back(v);
        names.push_back(nm);
    endtask

    // Drive one step, queue its expectation, then advance ncyc rising edges and
    // stop on the following falling edge (or 1 ns later for an immediate check).
    task automatic applyStimulus(input vec_t v);
        resetn     = v.rn;
        pll_locked = v.lk;
        restart    = v.rs;
        exp_q.push_back(v.exp);
        if (v.ncyc == 0) begin
            #1;
        end else begin
            for (int i = 0; i < v.ncyc; i++) begin
                @(posedge clk);
                #1 restart = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic checkOutput(input string nm);
        logic [8:0] exp;
        logic [8:0] act;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL %s: no expectation queued", nm);
            return;
        end
        exp = exp_q.pop_front();
        act = {pll_rst, sys_rst_n, ready, fail, retry_cnt, state};
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got pll_rst=%b sys_rst_n=%b ready=%b fail=%b retry=%0d state=%0d, want pll_rst=%b sys_rst_n=%b ready=%b fail=%b retry=%0d state=%0d",
                     nm, act[8], act[7], act[6], act[5], act[4:3], act[2:0],
                     exp[8], exp[7], exp[6], exp[5], exp[4:3], exp[2:0]);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        resetn     = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;

        //    name                 rn  lk  rs  n   prst sys rdy fl retry state
        // power-up and first lock
        addv("reset_values",       0, 0, 0, 2,  1, 0, 0, 0, 2'd0, 3'd0);
        addv("rst_edge3",          1, 0, 0, 3,  1, 0, 0, 0, 2'd0, 3'd0);
        addv("rst_edge4_wait",     1, 0, 0, 1,  0, 0, 0, 0, 2'd0, 3'd1);
        addv("wait_edge10",        1, 0, 0, 6,  0, 0, 0, 0, 2'd0, 3'd1);
        addv("lock_sync_delay",    1, 1, 0, 2,  0, 0, 0, 0, 2'd0, 3'd1);
        addv("enter_stable",       1, 1, 0, 1,  0, 0, 0, 0, 2'd0, 3'd2);
        addv("stable_n_plus_10",   1, 1, 0, 7,  0, 0, 0, 0, 2'd0, 3'd2);
        addv("run_n_plus_11",      1, 1, 0, 1,  0, 1, 1, 0, 2'd0, 3'd3);
        // lock loss in run
        addv("loss_edge2_run",     1, 0, 0, 2,  0, 1, 1, 0, 2'd0, 3'd3);
        addv("loss_edge3_pllrst",  1, 0, 0, 1,  1, 0, 0, 0, 2'd0, 3'd0);
        addv("loss_pulse_mid",     1, 0, 0, 2,  1, 0, 0, 0, 2'd0, 3'd0);
        addv("loss_pulse_end",     1, 1, 0, 2,  0, 0, 0, 0, 2'd0, 3'd1);
        addv("relock_stable",      1, 1, 0, 1,  0, 0, 0, 0, 2'd0, 3'd2);
        addv("relock_stable_7",    1, 1, 0, 7,  0, 0, 0, 0, 2'd0, 3'd2);
        addv("relock_run",         1, 1, 0, 1,  0, 1, 1, 0, 2'd0, 3'd3);
        // glitch in stable
        addv("restart_from_run",   1, 1, 1, 1,  1, 0, 0, 0, 2'd0, 3'd0);
        addv("g_wait",             1, 1, 0, 4,  0, 0, 0, 0, 2'd0, 3'd1);
        addv("g_stable",           1, 1, 0, 1,  0, 0, 0, 0, 2'd0, 3'd2);
        addv("g_stable_cnt5",      1, 1, 0, 5,  0, 0, 0, 0, 2'd0, 3'd2);
        addv("g_drop_in_pipe",     1, 0, 0, 2,  0, 0, 0, 0, 2'd0, 3'd2);
        addv("g_back_to_wait",     1, 1, 0, 1,  0, 0, 0, 0, 2'd0, 3'd1);
        addv("g_stable_again",     1, 1, 0, 2,  0, 0, 0, 0, 2'd0, 3'd2);
        addv("g_full_window_7",    1, 1, 0, 7,  0, 0, 0, 0, 2'd0, 3'd2);
        addv("g_run",              1, 1, 0, 1,  0, 1, 1, 0, 2'd0, 3'd3);
        // timeouts to sticky failure
        addv("t_run_loss",         1, 0, 0, 3,  1, 0, 0, 0, 2'd0, 3'd0);
        addv("t_wait1",            1, 0, 0, 4,  0, 0, 0, 0, 2'd0, 3'd1);
        addv("t_wait1_last",       1, 0, 0, 31, 0, 0, 0, 0, 2'd0, 3'd1);
        addv("t_timeout1",         1, 0, 0, 1,  1, 0, 0, 0, 2'd1, 3'd0);
        addv("t_wait2",            1, 0, 0, 4,  0, 0, 0, 0, 2'd1, 3'd1);
        addv("t_timeout2",         1, 0, 0, 32, 1, 0, 0, 0, 2'd2, 3'd0);
        addv("t_wait3_last",       1, 0, 0, 35, 0, 0, 0, 0, 2'd2, 3'd1);
        addv("t_enter_fail",       1, 0, 0, 1,  1, 0, 0, 1, 2'd2, 3'd4);
        addv("t_fail_sticky",      1, 0, 0, 50, 1, 0, 0, 1, 2'd2, 3'd4);
        // recovery from failure
        addv("r_restart",          1, 1, 1, 1,  1, 0, 0, 0, 2'd0, 3'd0);
        addv("r_wait",             1, 1, 0, 4,  0, 0, 0, 0, 2'd0, 3'd1);
        addv("r_stable",           1, 1, 0, 1,  0, 0, 0, 0, 2'd0, 3'd2);
        addv("r_run",              1, 1, 0, 8,  0, 1, 1, 0, 2'd0, 3'd3);
        // restart colliding with stable->run, then async reset mid-stable
        addv("c_restart",          1, 1, 1, 1,  1, 0, 0, 0, 2'd0, 3'd0);
        addv("c_wait",             1, 1, 0, 4,  0, 0, 0, 0, 2'd0, 3'd1);
        addv("c_stable",           1, 1, 0, 1,  0, 0, 0, 0, 2'd0, 3'd2);
        addv("c_stable_last",      1, 1, 0, 7,  0, 0, 0, 0, 2'd0, 3'd2);
        addv("c_restart_wins",     1, 1, 1, 1,  1, 0, 0, 0, 2'd0, 3'd0);
        addv("c_rst_full_len",     1, 1, 0, 4,  0, 0, 0, 0, 2'd0, 3'd1);
        addv("a_stable",           1, 1, 0, 1,  0, 0, 0, 0, 2'd0, 3'd2);
        addv("a_stable_mid",       1, 1, 0, 3,  0, 0, 0, 0, 2'd0, 3'd2);
        addv("a_async_reset_now",  0, 1, 0, 0,  1, 0, 0, 0, 2'd0, 3'd0);
        addv("a_reset_held",       0, 1, 0, 3,  1, 0, 0, 0, 2'd0, 3'd0);
        addv("a_release_wait",     1, 1, 0, 4,  0, 0, 0, 0, 2'd0, 3'd1);
        addv("a_release_stable",   1, 1, 0, 1,  0, 0, 0, 0, 2'd0, 3'd2);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(names[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
